rx_peak_search_nch: RTL

//  Parametrised successor to the 16-sequence correlator buffer. Captures NUM_SEQ correlator outputs on each new sample.

---
 rtl/rx_peak_search_nch.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/rx_peak_search_nch.sv
// -----------------------------------------------------------------------------
// rx_peak_search_nch
// Captures NUM_SEQ correlator outputs per sample trigger into a shadow bank,
// scans them one channel per clock and keeps the strongest peak seen over a
// WIN_LEN-sample window. At window end the peak value, channel index and
// sample timestamp are presented to the ARM side with a one-cycle strobe.
//
// Build option:
//   RX_PEAK_ABS_EN  defined   -> metric is |x| (most-negative saturates to
//                                2^(CORR_W-1)-1), o_sample_arm is a magnitude
//                   undefined -> metric is the signed sample; negative values
//                                never qualify against a non-negative threshold
// -----------------------------------------------------------------------------
module rx_peak_search_nch #(
  parameter int NUM_SEQ = 16,
  parameter int SEQ_W   = 4,
  parameter int CORR_W  = 41,
  parameter int TIME_W  = 16,
  parameter int WIN_LEN = 1024
) (
  input  logic                        crx_clk,
  input  logic                        rrx_rst,
  input  logic                        erx_en,
  input  logic                        inew_samle_trigger,
  input  logic [NUM_SEQ*CORR_W-1:0]   isample_corr_flat,
  input  logic [CORR_W-1:0]           ithreshold,
  output logic [CORR_W-1:0]           o_sample_arm,
  output logic [SEQ_W-1:0]            o_received_seq,
  output logic [TIME_W-1:0]           o_time_arm,
  output logic                        o_trigger_arm,
  output logic                        o_overrun
);

  localparam int                WIN_W    = $clog2(WIN_LEN);
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(WIN_LEN - 1);
  localparam logic [SEQ_W-1:0]  CH_LAST  = SEQ_W'(NUM_SEQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Peak metric of one raw correlator sample.
  function automatic logic signed [CORR_W-1:0] f_metric(input logic signed [CORR_W-1:0] x);
    logic signed [CORR_W-1:0] most_neg;
    logic signed [CORR_W-1:0] most_pos;
    most_neg = {1'b1, {(CORR_W-1){1'b0}}};
    most_pos = {1'b0, {(CORR_W-1){1'b1}}};
`ifdef RX_PEAK_ABS_EN
    if (x == most_neg) begin
      return most_pos;
    end else if (x[CORR_W-1]) begin
      return -x;
    end else begin
      return x;
    end
`else
    // Signed metric passes through; the limits are only used in the abs build.
    if ((x == most_neg) || (x == most_pos)) begin
      return x;
    end else begin
      return x;
    end
`endif
  endfunction

  state_t                       state_r;
  state_t                       state_nxt_s;

  logic [NUM_SEQ*CORR_W-1:0]    shadow_r;
  logic [SEQ_W-1:0]             ch_r;
  logic [TIME_W-1:0]            samp_cnt_r;
  logic [TIME_W-1:0]            ts_r;
  logic [WIN_W-1:0]             win_cnt_r;
  logic                         win_last_r;
  logic signed [CORR_W-1:0]     best_metric_r;
  logic [SEQ_W-1:0]             best_seq_r;
  logic [TIME_W-1:0]            best_time_r;
  logic                         best_valid_r;

  logic [CORR_W-1:0]            sample_arm_r;
  logic [SEQ_W-1:0]             received_seq_r;
  logic [TIME_W-1:0]            time_arm_r;
  logic                         trigger_arm_r;
  logic                         overrun_r;

  logic                         accept_s;
  logic                         drop_s;
  logic                         upd_s;
  logic                         eow_s;
  logic signed [CORR_W-1:0]     cur_raw_s;
  logic signed [CORR_W-1:0]     metric_s;
  logic signed [CORR_W:0]       metric_ext_s;
  logic signed [CORR_W:0]       thr_ext_s;

  assign o_sample_arm   = sample_arm_r;
  assign o_received_seq = received_seq_r;
  assign o_time_arm     = time_arm_r;
  assign o_trigger_arm  = trigger_arm_r;
  assign o_overrun      = overrun_r;

  // Trigger qualification, current-channel metric and window-end decode.
  always_comb begin
    accept_s     = 1'b0;
    drop_s       = 1'b0;
    upd_s        = 1'b0;
    eow_s        = 1'b0;
    cur_raw_s    = shadow_r[int'(ch_r)*CORR_W +: CORR_W];
    metric_s     = f_metric(cur_raw_s);
    metric_ext_s = {metric_s[CORR_W-1], metric_s};
    thr_ext_s    = {1'b0, ithreshold};
    if (erx_en && inew_samle_trigger) begin
      // A trigger in DONE is taken because IDLE behaviour applies on that edge.
      if ((state_r == ST_IDLE) || (state_r == ST_DONE)) begin
        accept_s = 1'b1;
      end else begin
        drop_s = 1'b1;
      end
    end else begin
      accept_s = 1'b0;
      drop_s   = 1'b0;
    end
    // Strict greater-than keeps the earlier sample and the lower channel on ties.
    if ((state_r == ST_SCAN) && (metric_s > best_metric_r) && (metric_ext_s >= thr_ext_s)) begin
      upd_s = 1'b1;
    end else begin
      upd_s = 1'b0;
    end
    if ((state_r == ST_DONE) && win_last_r) begin
      eow_s = 1'b1;
    end else begin
      eow_s = 1'b0;
    end
  end

  // Next-state logic of the capture/scan/report sequencer.
  always_comb begin
    state_nxt_s = state_r;
    if (!erx_en) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (inew_samle_trigger) begin
            state_nxt_s = ST_SCAN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_SCAN: begin
          if (ch_r == CH_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_SCAN;
          end
        end
        ST_DONE: begin
          if (inew_samle_trigger) begin
            state_nxt_s = ST_SCAN;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // Sequencer state register.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture, scan tracking, window bookkeeping and registered ARM outputs.
  always_ff @(posedge crx_clk or posedge rrx_rst) begin
    if (rrx_rst) begin
      shadow_r       <= {(NUM_SEQ*CORR_W){1'b0}};
      ch_r           <= {SEQ_W{1'b0}};
      samp_cnt_r     <= {TIME_W{1'b0}};
      ts_r           <= {TIME_W{1'b0}};
      win_cnt_r      <= {WIN_W{1'b0}};
      win_last_r     <= 1'b0;
      best_metric_r  <= {CORR_W{1'b0}};
      best_seq_r     <= {SEQ_W{1'b0}};
      best_time_r    <= {TIME_W{1'b0}};
      best_valid_r   <= 1'b0;
      sample_arm_r   <= {CORR_W{1'b0}};
      received_seq_r <= {SEQ_W{1'b0}};
      time_arm_r     <= {TIME_W{1'b0}};
      trigger_arm_r  <= 1'b0;
      overrun_r      <= 1'b0;
    end else if (!erx_en) begin
      // Disabled: restart the window from scratch, reported values hold.
      ch_r          <= {SEQ_W{1'b0}};
      samp_cnt_r    <= {TIME_W{1'b0}};
      win_cnt_r     <= {WIN_W{1'b0}};
      win_last_r    <= 1'b0;
      best_metric_r <= {CORR_W{1'b0}};
      best_valid_r  <= 1'b0;
      trigger_arm_r <= 1'b0;
    end else begin
      trigger_arm_r <= 1'b0;
      if (drop_s) begin
        overrun_r <= 1'b1;
      end
      if (state_r == ST_SCAN) begin
        ch_r <= ch_r + 1'b1;
        if (upd_s) begin
          best_metric_r <= metric_s;
          best_seq_r    <= ch_r;
          best_time_r   <= ts_r;
          best_valid_r  <= 1'b1;
        end
      end
      if (eow_s) begin
        if (best_valid_r) begin
          sample_arm_r   <= best_metric_r;
          received_seq_r <= best_seq_r;
          time_arm_r     <= best_time_r;
          trigger_arm_r  <= 1'b1;
        end
        best_valid_r  <= 1'b0;
        best_metric_r <= {CORR_W{1'b0}};
        win_cnt_r     <= {WIN_W{1'b0}};
        win_last_r    <= 1'b0;
      end
      // Accept last so a DONE-cycle trigger starts the next sample cleanly.
      if (accept_s) begin
        shadow_r   <= isample_corr_flat;
        ts_r       <= samp_cnt_r;
        samp_cnt_r <= samp_cnt_r + 1'b1;
        ch_r       <= {SEQ_W{1'b0}};
        win_last_r <= (win_cnt_r == WIN_LAST);
        if (win_cnt_r == WIN_LAST) begin
          win_cnt_r <= {WIN_W{1'b0}};
        end else begin
          win_cnt_r <= win_cnt_r + 1'b1;
        end
      end
    end
  end

endmodule
